// File: rtl/parity_pkg.sv
// -----------------------------------------------------------------------------
// parity_pkg
//   Shared definitions for the parity streaming unit:
//     - state_e        : frame tracking state (IDLE between frames, ACTIVE inside)
//     - PARITY_EVEN/ODD: values of the parity mode bit
//     - reduce_par     : reduction parity of a word of arbitrary width
// -----------------------------------------------------------------------------
package parity_pkg;

    typedef enum logic [0:0] {
        IDLE   = 1'b0,
        ACTIVE = 1'b1
    } state_e;

    localparam logic PARITY_EVEN = 1'b0;
    localparam logic PARITY_ODD  = 1'b1;

    // Widest word the parity helper accepts. Callers zero-extend narrower words
    // into this width; zero bits do not change the XOR reduction.
    localparam int PAR_MAX_W = 1024;

    // Reduction parity over the low 'width' bits of 'value'. Bits at or above
    // 'width' are ignored so callers need not guarantee a clean extension.
    function automatic logic reduce_par(input logic [PAR_MAX_W-1:0] value,
                                        input int unsigned          width);
        logic p;
        p = 1'b0;
        for (int unsigned i = 0; i < PAR_MAX_W; i++) begin
            if (i < width) begin
                p = p ^ value[i];
            end
        end
        return p;
    endfunction

endpackage

// File: rtl/parity_err_counter.sv
// -----------------------------------------------------------------------------
// parity_err_counter
//   Saturating event counter with a synchronous clear.
//   Ports:
//     clk    in   clock, rising edge
//     rst_n  in   asynchronous active-low reset
//     clr    in   synchronous clear; wins over inc, but an inc in the same
//                 cycle is still counted (result 1)
//     inc    in   count one event this cycle
//     count  out  CNT_W-bit count, holds at all-ones
// -----------------------------------------------------------------------------
module parity_err_counter #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             inc,
    output logic [CNT_W-1:0] count
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clr) begin
            // Clearing must not lose an error that lands in the same cycle.
            count <= inc ? CNT_W'(1) : '0;
        end else if (inc && (count != CNT_MAX)) begin
            count <= count + CNT_W'(1);
        end
    end

endmodule

// File: rtl/parity_stream_unit.sv
// -----------------------------------------------------------------------------
// parity_stream_unit
//   Streaming parity generator/checker with one registered pipeline stage.
//   Each accepted word gets a generated parity bit and an optional check of
//   the received parity; words are grouped into frames (closed by in_last or
//   after MAX_FRAME words) and a frame parity is reported when a frame closes.
//
//   Handshake (both sides): a word moves when valid && ready are both high at
//   a rising edge. in_ready = !out_valid || out_ready, so the single output
//   register is refilled in the same cycle it drains. While out_valid is high
//   and out_ready is low, all out_* hold their values.
//
//   Ports:
//     clk, rst_n        clock (rising edge), async active-low reset
//     cfg_odd           parity mode for the next frame (0 even, 1 odd)
//     chk_en            enable checking of in_par
//     clr_count         synchronous clear of err_count
//     in_valid/in_ready input handshake
//     in_data, in_par   input word and its received parity bit
//     in_last           last word of a frame
//     out_valid/out_ready output handshake
//     out_data          registered input word
//     out_par           generated parity of out_data
//     out_err           received parity mismatch (0 when checking disabled)
//     out_last          word closed its frame (in_last or MAX_FRAME reached)
//     frame_valid       one-cycle pulse when the closing word is first shown
//     frame_par         frame parity, valid with frame_valid
//     frame_trunc       frame closed by MAX_FRAME without in_last
//     err_count         saturating count of words with out_err=1
// -----------------------------------------------------------------------------
module parity_stream_unit
    import parity_pkg::*;
#(
    parameter int DATA_W    = 8,
    parameter int MAX_FRAME = 16,
    parameter int CNT_W     = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cfg_odd,
    input  logic              chk_en,
    input  logic              clr_count,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_par,
    input  logic              in_last,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_par,
    output logic              out_err,
    output logic              out_last,
    output logic              frame_valid,
    output logic              frame_par,
    output logic              frame_trunc,
    output logic [CNT_W-1:0]  err_count
);

    // Word counter wide enough to hold MAX_FRAME itself.
    localparam int CW = (MAX_FRAME > 1) ? $clog2(MAX_FRAME + 1) : 1;
    localparam logic [CW-1:0] FRAME_LIMIT = CW'(MAX_FRAME);

    state_e        state;
    logic [CW-1:0] count;
    logic          acc;
    logic          mode_q;

    logic          xfer;
    logic          mode_eff;
    logic          data_par;
    logic          word_par;
    logic          word_err;
    logic [CW-1:0] count_next;
    logic          acc_next;
    logic          close;

    assign in_ready = !out_valid || out_ready;
    assign xfer     = in_valid && in_ready;

    // The first word of a frame sees cfg_odd directly; later words use the
    // value latched with that first word, so mid-frame changes wait a frame.
    assign mode_eff = (state == IDLE) ? cfg_odd : mode_q;

    assign data_par = reduce_par(PAR_MAX_W'(in_data), DATA_W);
    assign word_par = data_par ^ mode_eff;
    assign word_err = chk_en && (in_par != word_par);

    // Count and accumulator as they stand including the current word.
    assign count_next = (state == IDLE) ? CW'(1) : (count + CW'(1));
    assign acc_next   = ((state == IDLE) ? 1'b0 : acc) ^ data_par;
    assign close      = in_last || (count_next == FRAME_LIMIT);

    // Frame tracking.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            count  <= '0;
            acc    <= 1'b0;
            mode_q <= PARITY_EVEN;
        end else if (xfer) begin
            if (close) begin
                state <= IDLE;
                count <= '0;
                acc   <= 1'b0;
            end else begin
                state <= ACTIVE;
                count <= count_next;
                acc   <= acc_next;
            end
            mode_q <= mode_eff;
        end
    end

    // Output word register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_par   <= 1'b0;
            out_err   <= 1'b0;
            out_last  <= 1'b0;
        end else if (xfer) begin
            out_valid <= 1'b1;
            out_data  <= in_data;
            out_par   <= word_par;
            out_err   <= word_err;
            out_last  <= close;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

    // Frame report: pulses together with the first presentation of the
    // closing word and does not wait for out_ready.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frame_valid <= 1'b0;
            frame_par   <= 1'b0;
            frame_trunc <= 1'b0;
        end else if (xfer && close) begin
            frame_valid <= 1'b1;
            frame_par   <= acc_next ^ mode_eff;
            frame_trunc <= !in_last;
        end else begin
            frame_valid <= 1'b0;
            frame_par   <= 1'b0;
            frame_trunc <= 1'b0;
        end
    end

    parity_err_counter #(
        .CNT_W (CNT_W)
    ) u_err_counter (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (clr_count),
        .inc   (xfer && word_err),
        .count (err_count)
    );

endmodule

// File: tb/tb_parity_stream_unit.sv
module tb_parity_stream_unit;

  localparam int DATA_W    = 8;
  localparam int MAX_FRAME = 4;
  localparam int CNT_W     = 2;
  localparam int ERR_MAX   = (1 << CNT_W) - 1;
  localparam int W         = DATA_W + 3;

  // ---------------- clock / reset ----------------
  logic clk;
  logic rst_n;
  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic              cfg_odd, chk_en, clr_count;
  logic              in_valid, in_ready;
  logic [DATA_W-1:0] in_data;
  logic              in_par, in_last;
  logic              out_valid, out_ready;
  logic [DATA_W-1:0] out_data;
  logic              out_par, out_err, out_last;
  logic              frame_valid, frame_par, frame_trunc;
  logic [CNT_W-1:0]  err_count;

  parity_stream_unit #(
    .DATA_W    (DATA_W),
    .MAX_FRAME (MAX_FRAME),
    .CNT_W     (CNT_W)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .cfg_odd     (cfg_odd),
    .chk_en      (chk_en),
    .clr_count   (clr_count),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_data     (in_data),
    .in_par      (in_par),
    .in_last     (in_last),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_data    (out_data),
    .out_par     (out_par),
    .out_err     (out_err),
    .out_last    (out_last),
    .frame_valid (frame_valid),
    .frame_par   (frame_par),
    .frame_trunc (frame_trunc),
    .err_count   (err_count)
  );

  // ---------------- scoreboard state ----------------
  int checks = 0;
  int passes = 0;

  logic [W-1:0] exp_q[$];    // {data, par, err, last}
  logic [1:0]   frame_q[$];  // {frame_par, frame_trunc}

  // Reference model of the frame: words seen, total set bits, latched mode.
  bit m_in_frame = 0;
  int m_mode     = 0;
  int m_words    = 0;
  int m_ones     = 0;
  int m_err      = 0;

  logic drv_xfer    = 1'b0;
  bit   rst_checked = 0;
  bit   bp_force    = 0;
  bit   rand_ready  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // Behavioural model: parity by counting set bits, frames by word count.
  task automatic model_step(input logic acc, input logic [DATA_W-1:0] d, input logic p,
                            input logic l, input logic odd, input logic chk, input logic clr);
    int   ones;
    logic op, er, cl;
    er = 1'b0;
    if (acc) begin
      if (!m_in_frame) begin
        m_mode  = odd ? 1 : 0;
        m_words = 0;
        m_ones  = 0;
      end
      ones    = $countones(d);
      m_words = m_words + 1;
      m_ones  = m_ones + ones;
      op = ((ones + m_mode) % 2) == 1;
      er = chk && (p != op);
      cl = l || (m_words == MAX_FRAME);
      exp_q.push_back({d, op, er, cl});
      if (cl) begin
        frame_q.push_back({((m_ones + m_mode) % 2) == 1, !l});
        m_in_frame = 0;
      end else begin
        m_in_frame = 1;
      end
    end
    if (clr) m_err = (acc && er) ? 1 : 0;
    else if (acc && er && m_err < ERR_MAX) m_err = m_err + 1;
  endtask

  // ---------------- driver tasks ----------------
  // Inputs change at the falling edge; the transfer decision is taken 2 time
  // units later, once in_ready has settled for the coming rising edge.
  task automatic drive_cycle(input logic v, input logic [DATA_W-1:0] d, input logic p,
                             input logic l, input logic odd, input logic chk,
                             input logic clr, output logic acc);
    @(negedge clk);
    in_valid  = v;
    in_data   = d;
    in_par    = p;
    in_last   = l;
    cfg_odd   = odd;
    chk_en    = chk;
    clr_count = clr;
    #2;
    acc = v && in_ready;
    model_step(acc, d, p, l, odd, chk, clr);
    drv_xfer = acc;
  endtask

  task automatic send(input logic [DATA_W-1:0] d, input logic p, input logic l,
                      input logic odd, input logic chk, input logic clr);
    logic acc;
    int   n;
    acc = 1'b0;
    n   = 0;
    while (!acc && n < 200) begin
      drive_cycle(1'b1, d, p, l, odd, chk, clr, acc);
      n++;
    end
    if (!acc) begin
      checks++;
      $display("FAIL send_timeout: word %0h not accepted within 200 cycles", d);
    end
  endtask

  task automatic idle(input int n, input logic clr);
    logic acc;
    for (int i = 0; i < n; i++) drive_cycle(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0, clr, acc);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    clr_count = 1'b0;
    #2;
    exp_q.delete();
    frame_q.delete();
    m_in_frame = 0;
    m_err      = 0;
    drv_xfer   = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  // ---------------- downstream ready ----------------
  initial begin
    out_ready = 1'b1;
    forever begin
      @(negedge clk);
      if (bp_force) out_ready = 1'b0;
      else if (rand_ready) out_ready = ($urandom_range(0, 9) < 7);
      else out_ready = 1'b1;
    end
  end

  // ---------------- monitor ----------------
  initial begin
    forever begin
      @(negedge clk);
      #1;
      if (!rst_n) begin
        if (!rst_checked) begin
          check("reset_outputs",
                {out_valid, out_data, out_par, out_err, out_last,
                 frame_valid, frame_par, frame_trunc, err_count}, '0);
          check("reset_in_ready", in_ready, 1);
          rst_checked = 1;
        end
      end else begin
        rst_checked = 0;
        if (drv_xfer) check("latency_out_valid", out_valid, 1);
        check("in_ready_rule", in_ready, !out_valid || out_ready);
        if (out_valid) begin
          if (exp_q.size() == 0) begin
            checks++;
            $display("FAIL word_unexpected: data %0h with empty expected queue", out_data);
          end else begin
            check("word", {out_data, out_par, out_err, out_last}, exp_q[0]);
            if (out_ready) void'(exp_q.pop_front());
          end
        end
        if (frame_valid) begin
          check("frame_with_last_word", {out_valid, out_last}, 2'b11);
          if (frame_q.size() == 0) begin
            checks++;
            $display("FAIL frame_unexpected: par %0b trunc %0b with empty queue",
                     frame_par, frame_trunc);
          end else begin
            check("frame", {frame_par, frame_trunc}, frame_q.pop_front());
          end
        end
        check("err_count", err_count, m_err);
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    in_par    = 1'b0;
    in_last   = 1'b0;
    cfg_odd   = 1'b0;
    chk_en    = 1'b0;
    clr_count = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    idle(2, 1'b0);

    // even mode, three words, third carries a parity error
    send(8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    send(8'h01, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    send(8'h03, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
    idle(3, 1'b0);

    // odd mode single-word frame
    send(8'hFF, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
    idle(3, 1'b0);

    // mode latched at the first word of a frame
    send(8'h12, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    send(8'h34, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    send(8'h57, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
    send(8'h01, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
    idle(2, 1'b1);

    // forced close at MAX_FRAME, fifth word opens a new frame
    for (int i = 0; i < 5; i++) send(8'(8'h20 + i), 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    send(8'hA5, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    idle(3, 1'b0);

    // backpressure: downstream stalls while words keep arriving
    fork
      begin
        bp_force = 1;
        repeat (4) @(negedge clk);
        bp_force = 0;
      end
      begin
        send(8'h81, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        send(8'h82, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        send(8'h83, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
      end
    join
    idle(3, 1'b0);

    // error counter saturation, then clear with and without a coincident error
    for (int i = 0; i < 5; i++) send(8'h00, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    idle(2, 1'b0);
    send(8'h00, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1);
    idle(2, 1'b0);
    idle(1, 1'b1);
    idle(2, 1'b0);

    // reset in the middle of a frame discards it
    send(8'h11, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    send(8'h22, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    do_reset();
    idle(2, 1'b0);
    send(8'h33, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
    idle(2, 1'b0);

    // randomized traffic with random downstream stalls
    rand_ready = 1;
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 3) == 0) idle(1, ($urandom_range(0, 19) == 0));
      send(8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)),
           ($urandom_range(0, 4) == 0), 1'($urandom_range(0, 1)),
           ($urandom_range(0, 3) != 0), ($urandom_range(0, 19) == 0));
    end
    rand_ready = 0;

    // drain
    for (int i = 0; i < 50 && exp_q.size() != 0; i++) idle(1, 1'b0);
    idle(2, 1'b0);
    check("drain_word_queue", exp_q.size(), 0);
    check("drain_frame_queue", frame_q.size(), 0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
